axi_m_if: RTL

// - Crossbar-side AXI master port facing one slave; the opposite end of the per-master slave-side interface.
// - Accepts granted AR/AW/W packets from the crossbar arbiters and drives them onto the slave's AXI channels.
// - Buffers slave R/B responses and steers each one back to the originating master.
// - Routing uses the master index held in ID[7:4]. Single clock domain (AXI side).

---
 rtl/axi_xbar_pkg.sv | 48 ++++
 rtl/axi_m_if_sync_fifo.sv | 46 ++++
 rtl/axi_m_if.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/axi_xbar_pkg.sv
// Shared packet layouts, width constants and routing helper for the AXI crossbar.
// Every field is packed MSB-first, in the order the arbiters concatenate it.
package axi_xbar_pkg;

    localparam int M_CNT  = 6;
    localparam int ID_W   = 8;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    typedef struct packed {
        logic [ID_W-1:0]   id;
        logic [ADDR_W-1:0] addr;
        logic [3:0]        len;
        logic [2:0]        size;
        logic [1:0]        burst;
    } ar_pkt_t;

    typedef struct packed {
        logic [DATA_W-1:0]   data;
        logic [DATA_W/8-1:0] strb;
        logic                last;
    } w_pkt_t;

    typedef struct packed {
        logic [ID_W-1:0]   id;
        logic [DATA_W-1:0] data;
        logic [1:0]        resp;
        logic              last;
    } r_pkt_t;

    typedef struct packed {
        logic [ID_W-1:0] id;
        logic [1:0]      resp;
    } b_pkt_t;

    typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA, W_RESP} wstate_e;

    // The originating master index lives in id[7:4]; indices past M_CNT map to all-zero.
    function automatic logic [M_CNT-1:0] onehot_mid(input logic [ID_W-1:0] id);
        logic [M_CNT-1:0] oh;
        oh = '0;
        for (int i = 0; i < M_CNT; i++) begin
            if (id[7:4] == 4'(i)) oh[i] = 1'b1;
        end
        return oh;
    endfunction

endpackage

// File: rtl/axi_m_if_sync_fifo.sv
// Single-clock FIFO with first-word fall-through read port.
// Push while full and pop while empty are ignored.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      rd_ptr_q;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign rdata   = mem[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    // NOTE: storage is deliberately left unreset; the pointers alone decide which entries are valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_q[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/axi_m_if.sv
// Crossbar-side AXI master port for one slave: forwards granted AR/AW/W packets
// and steers buffered R/B responses back to the master named in ID[7:4].
module axi_m_if #(
    parameter logic [3:0] S_NUM   = 4'd0,
    parameter int         R_DEPTH = 4,
    parameter int         M_CNT   = 6
) (
    input  logic             AXI_CLK_i,
    input  logic             AXI_RST_i,
    input  logic             ar_grant_i,
    input  logic [48:0]      ar_data_i,
    output logic             ar_ready_o,
    input  logic             aw_grant_i,
    input  logic [48:0]      aw_data_i,
    output logic             aw_ready_o,
    input  logic             w_valid_i,
    input  logic [36:0]      w_data_i,
    output logic             w_ready_o,
    output logic [7:0]       ARID_o,
    output logic [31:0]      ARADDR_o,
    output logic [3:0]       ARLEN_o,
    output logic [2:0]       ARSIZE_o,
    output logic [1:0]       ARBURST_o,
    output logic             ARVALID_o,
    input  logic             ARREADY_i,
    output logic [7:0]       AWID_o,
    output logic [31:0]      AWADDR_o,
    output logic [3:0]       AWLEN_o,
    output logic [2:0]       AWSIZE_o,
    output logic [1:0]       AWBURST_o,
    output logic             AWVALID_o,
    input  logic             AWREADY_i,
    output logic [31:0]      WDATA_o,
    output logic [3:0]       WSTRB_o,
    output logic             WLAST_o,
    output logic             WVALID_o,
    input  logic             WREADY_i,
    input  logic [7:0]       RID_i,
    input  logic [31:0]      RDATA_i,
    input  logic [1:0]       RRESP_i,
    input  logic             RLAST_i,
    input  logic             RVALID_i,
    output logic             RREADY_o,
    input  logic [7:0]       BID_i,
    input  logic [1:0]       BRESP_i,
    input  logic             BVALID_i,
    output logic             BREADY_o,
    output logic [42:0]      r_data_o,
    output logic [M_CNT-1:0] r_req_o,
    input  logic [M_CNT-1:0] r_pop_i,
    output logic [9:0]       b_data_o,
    output logic [M_CNT-1:0] b_req_o,
    input  logic [M_CNT-1:0] b_pop_i,
    output logic             proto_err_o
);

    import axi_xbar_pkg::*;

    function automatic logic mid_ok(input logic [7:0] id);
        return int'(id[7:4]) < M_CNT;
    endfunction

    function automatic logic [M_CNT-1:0] mid_req(input logic [7:0] id);
        return M_CNT'(onehot_mid(id));
    endfunction

    // ---------------- AR: single holding register ----------------
    ar_pkt_t ar_q;
    logic    ar_vld_q;

    assign ar_ready_o = ~ar_vld_q;
    assign ARVALID_o  = ar_vld_q;
    assign ARID_o     = ar_q.id;
    assign ARADDR_o   = ar_q.addr;
    assign ARLEN_o    = ar_q.len;
    assign ARSIZE_o   = ar_q.size;
    assign ARBURST_o  = ar_q.burst;

    // NOTE: clocked state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge AXI_CLK_i or negedge AXI_RST_i) begin
        if (!AXI_RST_i) begin
            ar_vld_q <= 1'b0;
            ar_q     <= '0;
        end else if (ar_grant_i && ar_ready_o) begin
            ar_vld_q <= 1'b1;
            ar_q     <= ar_pkt_t'(ar_data_i);
        end else if (ARREADY_i) begin
            ar_vld_q <= 1'b0;
        end
    end

    // ---------------- Write path: one outstanding burst ----------------
    wstate_e    w_state_q, w_state_d;
    ar_pkt_t    aw_q;
    logic [3:0] beat_cnt_q;
    w_pkt_t     w_in;
    logic       w_hs;
    logic       w_err;
    logic       b_push;

    assign w_in      = w_pkt_t'(w_data_i);
    assign AWID_o    = aw_q.id;
    assign AWADDR_o  = aw_q.addr;
    assign AWLEN_o   = aw_q.len;
    assign AWSIZE_o  = aw_q.size;
    assign AWBURST_o = aw_q.burst;
    assign WDATA_o   = w_in.data;
    assign WSTRB_o   = w_in.strb;
    assign WLAST_o   = w_in.last;

    always_comb begin
        // NOTE: defaults first so no branch can leave an output unassigned and infer a latch.
        w_state_d  = w_state_q;
        aw_ready_o = 1'b0;
        AWVALID_o  = 1'b0;
        WVALID_o   = 1'b0;
        w_ready_o  = 1'b0;
        case (w_state_q)
            W_IDLE: begin
                aw_ready_o = 1'b1;
                if (aw_grant_i) w_state_d = W_ADDR;
            end
            W_ADDR: begin
                AWVALID_o = 1'b1;
                if (AWREADY_i) w_state_d = W_DATA;
            end
            W_DATA: begin
                WVALID_o  = w_valid_i;
                w_ready_o = WREADY_i;
                if (w_valid_i && WREADY_i && w_in.last) w_state_d = W_RESP;
            end
            W_RESP: begin
                if (b_push) w_state_d = W_IDLE;
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    // beat_cnt counts beats already accepted, so the final beat arrives with beat_cnt == len.
    assign w_hs  = (w_state_q == W_DATA) && w_valid_i && WREADY_i;
    assign w_err = w_hs && (w_in.last != (beat_cnt_q == aw_q.len));

    always_ff @(posedge AXI_CLK_i or negedge AXI_RST_i) begin
        if (!AXI_RST_i) begin
            w_state_q  <= W_IDLE;
            aw_q       <= '0;
            beat_cnt_q <= '0;
        end else begin
            w_state_q <= w_state_d;
            if (aw_ready_o && aw_grant_i) begin
                aw_q       <= ar_pkt_t'(aw_data_i);
                beat_cnt_q <= '0;
            end else if (w_hs) begin
                beat_cnt_q <= beat_cnt_q + 4'd1;
            end
        end
    end

    // ---------------- R: response FIFO, head routed to its master ----------------
    r_pkt_t                      r_in;
    r_pkt_t                      r_head;
    logic [$bits(r_pkt_t)-1:0]   r_head_raw;
    logic                        r_full;
    logic                        r_empty;
    logic                        r_push;
    logic                        r_pop;
    logic                        r_bad;

    assign r_in     = '{id: RID_i, data: RDATA_i, resp: RRESP_i, last: RLAST_i};
    assign r_head   = r_pkt_t'(r_head_raw);
    assign RREADY_o = ~r_full;
    assign r_push   = RVALID_i && RREADY_o;
    // An unroutable head is dropped on the next edge rather than blocking the FIFO.
    assign r_bad    = ~r_empty && ~mid_ok(r_head.id);
    assign r_req_o  = (r_empty || r_bad) ? '0 : mid_req(r_head.id);
    assign r_pop    = (|(r_pop_i & r_req_o)) || r_bad;
    assign r_data_o = r_head;

    sync_fifo #(
        .WIDTH ($bits(r_pkt_t)),
        .DEPTH (R_DEPTH)
    ) u_r_fifo (
        .clk   (AXI_CLK_i),
        .rst_n (AXI_RST_i),
        .push  (r_push),
        .wdata (r_in),
        .pop   (r_pop),
        .rdata (r_head_raw),
        .full  (r_full),
        .empty (r_empty)
    );

    // ---------------- B: single response register ----------------
    b_pkt_t b_q;
    logic   b_vld_q;
    logic   b_bad;
    logic   b_pop;

    assign BREADY_o = ~b_vld_q;
    assign b_push   = BVALID_i && BREADY_o;
    assign b_bad    = b_vld_q && ~mid_ok(b_q.id);
    assign b_req_o  = (b_vld_q && !b_bad) ? mid_req(b_q.id) : '0;
    assign b_pop    = (|(b_pop_i & b_req_o)) || b_bad;
    assign b_data_o = b_q;

    always_ff @(posedge AXI_CLK_i or negedge AXI_RST_i) begin
        if (!AXI_RST_i) begin
            b_vld_q <= 1'b0;
            b_q     <= '0;
        end else if (b_push) begin
            b_vld_q <= 1'b1;
            b_q     <= '{id: BID_i, resp: BRESP_i};
        end else if (b_pop) begin
            b_vld_q <= 1'b0;
        end
    end

    always_ff @(posedge AXI_CLK_i or negedge AXI_RST_i) begin
        if (!AXI_RST_i)                  proto_err_o <= 1'b0;
        else if (w_err || r_bad || b_bad) proto_err_o <= 1'b1;
    end

    a_w_only_in_data: assert property (@(posedge AXI_CLK_i) disable iff (!AXI_RST_i)
        (w_state_q != W_DATA) |-> !(WVALID_o || w_ready_o))
        else $error("axi_m_if slave %0d: W channel active outside W_DATA", S_NUM);

endmodule
